// File: rtl/xor_accum_unit_pkg.sv
// Shared definitions for the bitwise logic / XOR-accumulate execution slot:
// operation encodings and a helper that recognises the reserved op range.
package xor_accum_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NOR  = 3'b011;
  localparam op_t OP_XNOR = 3'b100;
  localparam op_t OP_ACC  = 3'b101;
  localparam op_t OP_RSV0 = 3'b110;
  localparam op_t OP_RSV1 = 3'b111;

  // Everything from OP_RSV0 upward is reserved.
  localparam op_t OP_RSV_FIRST = OP_RSV0;

  function automatic logic is_reserved_op(input op_t op);
    return (op >= OP_RSV_FIRST);
  endfunction

endpackage

// File: rtl/xor_accum_unit_if.sv
// Operand/result handshake bundle of the logic unit. The producer of operands
// and consumer of results uses the master view; the unit uses the slave view.
interface xor_accum_unit_if
  import xor_accum_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic             out_err;
  logic             acc_busy;

  modport master (
    output in_valid, op, a, b, last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_err, acc_busy
  );

  modport slave (
    input  in_valid, op, a, b, last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_err, acc_busy
  );

endinterface

// File: rtl/xor_accum_unit_bitwise_op_core.sv
// Purely combinational operation core: evaluates the selected bitwise function
// on a/b (and the running accumulator for ACC_XOR) and flags reserved codes.
module bitwise_op_core
  import xor_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  // Operation select; reserved codes fall back to a^b with the error flag set.
  always_comb begin
    o_result = i_a ^ i_b;
    o_err    = is_reserved_op(i_op);
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_XNOR: o_result = ~(i_a ^ i_b);
      OP_ACC:  o_result = i_acc ^ i_a ^ i_b;
      default: o_result = i_a ^ i_b;
    endcase
  end

endmodule

// File: rtl/xor_accum_unit.sv
// Registered bitwise logic slot with a multi-beat XOR accumulator. One beat is
// taken per cycle whenever the single output register is free or draining;
// non-last ACC beats only update the accumulator and produce no result.
module xor_accum_unit
  import xor_accum_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic           clk,
  input logic           rst_n,
  xor_accum_unit_if.slave bus
);

  logic [WIDTH-1:0] r_acc;
  logic             r_acc_busy;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_acc;
  logic             w_produce;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  bitwise_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op     (bus.op),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_acc    (r_acc),
    .o_result (w_result),
    .o_err    (w_err)
  );

  // The output register can take a new value when empty or being drained now.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_acc   = (bus.op == OP_ACC);
  // A beat produces a result unless it is a non-last accumulate beat.
  assign w_produce  = w_accept && (!w_is_acc || bus.last);

  // Output register: load on producing beats, clear valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_produce) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_err   <= w_err;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accumulator: folds in non-last ACC beats, rearms to ACC_INIT on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= ACC_INIT;
      r_acc_busy <= 1'b0;
    end else if (w_accept && w_is_acc) begin
      if (bus.last) begin
        r_acc      <= ACC_INIT;
        r_acc_busy <= 1'b0;
      end else begin
        r_acc      <= w_result;
        r_acc_busy <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  // Parity is derived from the held result so it stays stable under stall.
  assign bus.out_parity = ^r_out_data;
  assign bus.out_err    = r_out_err;
  assign bus.acc_busy   = r_acc_busy;

endmodule

// File: tb/tb_xor_accum_unit.sv
// Directed bench for xor_accum_unit: each scenario drives a few beats and
// compares the unit's outputs with hand-computed values.
module tb_xor_accum_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  xor_accum_unit_if #(.WIDTH(WIDTH)) bus ();

  xor_accum_unit #(
    .WIDTH    (WIDTH),
    .ACC_INIT (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic last);
    bus.in_valid = valid;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.last     = last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
    n_tests++; if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL rst_out_parity got %b exp 0", bus.out_parity); end
    n_tests++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err got %b exp 0", bus.out_err); end
    n_tests++; if (bus.acc_busy !== 1'b0) begin n_fail++; $display("FAIL rst_acc_busy got %b exp 0", bus.acc_busy); end
    rst_n = 1'b1;
    step();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_and();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL and_valid got %b exp 1", bus.out_valid); end
    n_tests++; if (bus.out_data !== 32'hF000F000) begin n_fail++; $display("FAIL and_data got %h exp f000f000", bus.out_data); end
    n_tests++; if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL and_parity got %b exp 0", bus.out_parity); end
    n_tests++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL and_err got %b exp 0", bus.out_err); end
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL and_valid_fall got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_nor_xnor();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b011, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b1, 3'b100, 32'h1, 32'h0, 1'b0);
    n_tests++; if (bus.out_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL nor_data got %h exp ffffffff", bus.out_data); end
    n_tests++; if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL nor_parity got %b exp 0", bus.out_parity); end
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL xnor_valid got %b exp 1", bus.out_valid); end
    n_tests++; if (bus.out_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL xnor_data got %h exp fffffffe", bus.out_data); end
    n_tests++; if (bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL xnor_parity got %b exp 1", bus.out_parity); end
    step();
  endtask

  task automatic test_acc();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b101, 32'h3, 32'h2, 1'b0);          // a^b = 1
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL acc1_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.acc_busy !== 1'b1) begin n_fail++; $display("FAIL acc1_busy got %b exp 1", bus.acc_busy); end
    // Ordinary XOR in the middle of an open sequence.
    drive(1'b1, 3'b010, 32'hA, 32'h5, 1'b1);
    step();
    n_tests++; if (bus.out_data !== 32'hF) begin n_fail++; $display("FAIL acc_mid_xor_data got %h exp f", bus.out_data); end
    n_tests++; if (bus.acc_busy !== 1'b1) begin n_fail++; $display("FAIL acc_mid_busy got %b exp 1", bus.acc_busy); end
    drive(1'b1, 3'b101, 32'h6, 32'h4, 1'b0);          // a^b = 2
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL acc2_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.acc_busy !== 1'b1) begin n_fail++; $display("FAIL acc2_busy got %b exp 1", bus.acc_busy); end
    drive(1'b1, 3'b101, 32'hC, 32'h8, 1'b1);          // a^b = 4, last
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL acc_last_valid got %b exp 1", bus.out_valid); end
    n_tests++; if (bus.out_data !== 32'h7) begin n_fail++; $display("FAIL acc_last_data got %h exp 7", bus.out_data); end
    n_tests++; if (bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL acc_last_parity got %b exp 1", bus.out_parity); end
    n_tests++; if (bus.acc_busy !== 1'b0) begin n_fail++; $display("FAIL acc_last_busy got %b exp 0", bus.acc_busy); end
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL acc_after_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b010, 32'h11, 32'h22, 1'b0);        // 0x33
    step();
    drive(1'b1, 3'b010, 32'h40, 32'h04, 1'b0);        // 0x44, held pending
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h33) begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h exp 1/33", i, bus.out_valid, bus.out_data); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44) begin n_fail++; $display("FAIL bp_second got %b/%h exp 1/44", bus.out_valid, bus.out_data); end
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_reserved();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b110, 32'h5, 32'h3, 1'b0);
    step();
    drive(1'b1, 3'b000, 32'hFF, 32'h0F, 1'b0);
    n_tests++; if (bus.out_data !== 32'h6) begin n_fail++; $display("FAIL rsv0_data got %h exp 6", bus.out_data); end
    n_tests++; if (bus.out_err !== 1'b1) begin n_fail++; $display("FAIL rsv0_err got %b exp 1", bus.out_err); end
    step();
    drive(1'b1, 3'b111, 32'h1, 32'h0, 1'b0);
    n_tests++; if (bus.out_data !== 32'h0F || bus.out_err !== 1'b0) begin n_fail++; $display("FAIL legal_after_rsv got %h/%b exp f/0", bus.out_data, bus.out_err); end
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.out_data !== 32'h1 || bus.out_err !== 1'b1) begin n_fail++; $display("FAIL rsv1 got %h/%b exp 1/1", bus.out_data, bus.out_err); end
    step();
  endtask

  task automatic test_reset_mid_acc();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b101, 32'h1, 32'h2, 1'b0);
    step();
    drive(1'b1, 3'b101, 32'h4, 32'h8, 1'b0);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.acc_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", bus.acc_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.acc_busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_async got %b/%b exp 0/0", bus.acc_busy, bus.out_valid); end
    step();
    rst_n = 1'b1;
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_partial got %b exp 0", bus.out_valid); end
    drive(1'b1, 3'b101, 32'hA, 32'h3, 1'b1);          // a^b = 9
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h9) begin n_fail++; $display("FAIL mid_rst_acc got %b/%h exp 1/9", bus.out_valid, bus.out_data); end
    n_tests++; if (bus.acc_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy_end got %b exp 0", bus.acc_busy); end
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_and();
    test_nor_xnor();
    test_acc();
    test_backpressure();
    test_reserved();
    test_reset_mid_acc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
